// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the convolution tile loader.
package conv_pkg;
  localparam int DATA_W  = 8;
  localparam int A_DIM   = 4;
  localparam int B_DIM   = 3;
  localparam int A_ELEMS = A_DIM * A_DIM;
  localparam int B_ELEMS = B_DIM * B_DIM;
  localparam int IDX_W   = $clog2(A_ELEMS);

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    WR_A   = 3'd2,
    WR_B   = 3'd3,
    HOLD   = 3'd4
  } state_e;
endpackage

// File: rtl/conv_elem_counter.sv
// Element index counter shared by the tile and kernel load phases.
module conv_elem_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last_val,
  output logic [W-1:0] idx,
  output logic         tc
);
  logic [W-1:0] idx_q, idx_d;

  assign idx = idx_q;
  assign tc  = (idx_q == last_val);

  // Wraps to zero after the terminal element so the next phase starts at 0.
  always_comb begin
    idx_d = idx_q;
    if (clr)
      idx_d = '0;
    else if (en)
      idx_d = tc ? '0 : idx_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) idx_q <= '0;
    else     idx_q <= idx_d;
  end
endmodule

// File: rtl/conv_tile_loader.sv
// Assembles a 4x4 tile and 3x3 kernel from a byte stream, then strobes them
// into the convolution datapath. Handshake: a byte moves on a clk edge where
// in_valid=1 and in_ready=1; in_data/keep_kernel must be stable while in_valid=1.
module conv_tile_loader import conv_pkg::*; #(
  parameter int DATA_W = conv_pkg::DATA_W,
  parameter int A_DIM  = conv_pkg::A_DIM,
  parameter int B_DIM  = conv_pkg::B_DIM
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_W-1:0]               in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            keep_kernel,
  output logic [A_DIM*A_DIM*DATA_W-1:0]   a_mat,
  output logic [B_DIM*B_DIM*DATA_W-1:0]   b_mat,
  output logic                            we_1,
  output logic                            we_2,
  output logic                            tile_valid,
  input  logic                            tile_ack,
  output logic [2:0]                      dbg_state
);
  localparam int AE = A_DIM * A_DIM;
  localparam int BE = B_DIM * B_DIM;
  localparam int IW = $clog2(AE);

  state_e                     state_q, state_d;
  logic [AE*DATA_W-1:0]       a_q, a_d;
  logic [BE*DATA_W-1:0]       b_q, b_d;
  logic                       kept_q, kept_d;
  logic                       we_1_q, we_1_d;
  logic                       we_2_q, we_2_d;
  logic                       tile_valid_q, tile_valid_d;
  logic                       in_ready_q, in_ready_d;
  logic                       accept;
  logic [IW-1:0]              idx;
  logic                       tc;
  logic [IW-1:0]              last_val;

  assign accept   = in_valid && in_ready_q;
  assign last_val = (state_q == LOAD_B) ? IW'(BE - 1) : IW'(AE - 1);

  conv_elem_counter #(.W(IW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (!in_ready_q),
    .en       (accept),
    .last_val (last_val),
    .idx      (idx),
    .tc       (tc)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    kept_d  = kept_q;
    case (state_q)
      LOAD_A: if (accept) begin
        a_d[int'(idx)*DATA_W +: DATA_W] = in_data;
        if (idx == '0) kept_d = keep_kernel;
        if (tc) state_d = kept_q ? WR_A : LOAD_B;
      end
      LOAD_B: if (accept) begin
        b_d[int'(idx)*DATA_W +: DATA_W] = in_data;
        if (tc) state_d = WR_A;
      end
      WR_A:    state_d = kept_q ? HOLD : WR_B;
      WR_B:    state_d = HOLD;
      HOLD:    if (tile_ack) state_d = LOAD_A;
      default: state_d = LOAD_A;
    endcase
    // Outputs are decoded from the next state so they are registered with it.
    we_1_d       = (state_d == WR_A);
    we_2_d       = (state_d == WR_B);
    tile_valid_d = (state_d == HOLD);
    in_ready_d   = (state_d == LOAD_A) || (state_d == LOAD_B);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD_A;
      a_q          <= '0;
      b_q          <= '0;
      kept_q       <= 1'b0;
      we_1_q       <= 1'b0;
      we_2_q       <= 1'b0;
      tile_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      kept_q       <= kept_d;
      we_1_q       <= we_1_d;
      we_2_q       <= we_2_d;
      tile_valid_q <= tile_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign a_mat      = a_q;
  assign b_mat      = b_q;
  assign we_1       = we_1_q;
  assign we_2       = we_2_q;
  assign tile_valid = tile_valid_q;
  assign in_ready   = in_ready_q;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_conv_tile_loader.sv
// Directed bench for conv_tile_loader: drives at negedge, samples at negedge.
module tb_conv_tile_loader;
  import conv_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         keep_kernel = 1'b0;
  logic [127:0] a_mat;
  logic [71:0]  b_mat;
  logic         we_1, we_2, tile_valid;
  logic         tile_ack = 1'b0;
  logic [2:0]   dbg_state;

  int tests_run = 0;
  int fails = 0;

  logic [7:0] a1 [16] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd2, 8'd3, 8'd4, 8'd5,
                          8'd3, 8'd4, 8'd5, 8'd5, 8'd3, 8'd4, 8'd5, 8'd5};
  logic [7:0] b1 [9]  = '{8'd9, 8'd8, 8'd7, 8'd8, 8'd7, 8'd6, 8'd7, 8'd6, 8'd5};
  logic [7:0] a3 [16];
  logic [7:0] b3 [9];

  always #5 clk = ~clk;

  conv_tile_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .keep_kernel(keep_kernel), .a_mat(a_mat),
    .b_mat(b_mat), .we_1(we_1), .we_2(we_2), .tile_valid(tile_valid),
    .tile_ack(tile_ack), .dbg_state(dbg_state)
  );

  function automatic logic [127:0] pack_a(input logic [7:0] v [16]);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = v[i];
    return r;
  endfunction

  function automatic logic [71:0] pack_b(input logic [7:0] v [9]);
    logic [71:0] r;
    for (int i = 0; i < 9; i++) r[i*8 +: 8] = v[i];
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] d, input logic kk);
    int n;
    n = 0;
    in_data = d; keep_kernel = kk; in_valid = 1'b1;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      tests_run++; fails++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_tile(input logic [7:0] av [16], input logic [7:0] bv [9],
                           input logic kk, input int max_gap);
    for (int i = 0; i < 16; i++) begin
      send_byte(av[i], kk);
      if (max_gap > 0 && !(kk && i == 15)) repeat ($urandom_range(max_gap, 1)) @(negedge clk);
    end
    if (!kk)
      for (int j = 0; j < 9; j++) begin
        send_byte(bv[j], 1'b0);
        if (max_gap > 0 && j != 8) repeat ($urandom_range(max_gap, 1)) @(negedge clk);
      end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (a_mat !== '0 || b_mat !== '0) begin fails++;
      $display("FAIL reset_mats: a=%h b=%h, required 0", a_mat, b_mat); end
    tests_run++;
    if ({we_1, we_2, tile_valid, in_ready} !== 4'b0001) begin fails++;
      $display("FAIL reset_ctrl: we1/we2/tv/rdy=%b, required 0001", {we_1, we_2, tile_valid, in_ready}); end
    tests_run++;
    if (dbg_state !== 3'(LOAD_A)) begin fails++;
      $display("FAIL reset_state: got %0d, required %0d", dbg_state, LOAD_A); end
    rst = 1'b0;
  endtask

  task automatic test_full_load;
    send_tile(a1, b1, 1'b0, 0);
    tests_run++;
    if (a_mat[7:0] !== 8'd1 || a_mat[127:120] !== 8'd5 || b_mat[7:0] !== 8'd9 || b_mat[71:64] !== 8'd5) begin
      fails++; $display("FAIL full_corners: a11=%0d a44=%0d b11=%0d b33=%0d, required 1 5 9 5",
                        a_mat[7:0], a_mat[127:120], b_mat[7:0], b_mat[71:64]); end
    tests_run++;
    if (a_mat !== pack_a(a1) || b_mat !== pack_b(b1)) begin fails++;
      $display("FAIL full_mats: a=%h b=%h, required a=%h b=%h", a_mat, b_mat, pack_a(a1), pack_b(b1)); end
    tests_run++;
    if ({we_1, we_2, tile_valid} !== 3'b100) begin fails++;
      $display("FAIL full_we1: we1/we2/tv=%b, required 100", {we_1, we_2, tile_valid}); end
    @(negedge clk);
    tests_run++;
    if ({we_1, we_2, tile_valid} !== 3'b010) begin fails++;
      $display("FAIL full_we2: we1/we2/tv=%b, required 010", {we_1, we_2, tile_valid}); end
    @(negedge clk);
    tests_run++;
    if ({we_1, we_2, tile_valid, in_ready} !== 4'b0010) begin fails++;
      $display("FAIL full_hold: we1/we2/tv/rdy=%b, required 0010", {we_1, we_2, tile_valid, in_ready}); end
  endtask

  task automatic test_backpressure;
    in_data = 8'd7; keep_kernel = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b0 || tile_valid !== 1'b1 || a_mat[7:0] !== 8'd1) begin fails++;
        $display("FAIL bp_hold: rdy=%b tv=%b a11=%0d, required 0 1 1", in_ready, tile_valid, a_mat[7:0]); end
    end
    tile_ack = 1'b1;
    @(negedge clk);
    tile_ack = 1'b0;
    tests_run++;
    if (tile_valid !== 1'b0 || in_ready !== 1'b1 || dbg_state !== 3'(LOAD_A)) begin fails++;
      $display("FAIL bp_ack: tv=%b rdy=%b st=%0d, required 0 1 %0d", tile_valid, in_ready, dbg_state, LOAD_A); end
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++;
    if (a_mat[7:0] !== 8'd7 || a_mat[15:8] !== 8'd2) begin fails++;
      $display("FAIL bp_first_byte: a11=%0d a12=%0d, required 7 2", a_mat[7:0], a_mat[15:8]); end
  endtask

  task automatic test_kernel_reuse;
    int we2_seen;
    // keep_kernel is only sampled with the first tile byte, so drive 0 here.
    for (int i = 1; i < 16; i++) send_byte(8'd7, 1'b0);
    tests_run++;
    if (we_1 !== 1'b1 || we_2 !== 1'b0 || a_mat !== {16{8'd7}}) begin fails++;
      $display("FAIL reuse_we1: we1=%b we2=%b a=%h, required 1 0 all-07", we_1, we_2, a_mat); end
    we2_seen = 0;
    @(negedge clk);
    if (we_2) we2_seen++;
    tests_run++;
    if (tile_valid !== 1'b1 || we_1 !== 1'b0) begin fails++;
      $display("FAIL reuse_tv: tv=%b we1=%b, required 1 0", tile_valid, we_1); end
    repeat (3) begin @(negedge clk); if (we_2) we2_seen++; end
    tests_run++;
    if (we2_seen != 0 || b_mat !== pack_b(b1)) begin fails++;
      $display("FAIL reuse_kernel: we2 pulses=%0d b=%h, required 0 %h", we2_seen, b_mat, pack_b(b1)); end
    tile_ack = 1'b1; @(negedge clk); tile_ack = 1'b0;
  endtask

  task automatic test_bubbles;
    send_tile(a1, b1, 1'b0, 3);
    tests_run++;
    if (a_mat !== pack_a(a1) || b_mat !== pack_b(b1)) begin fails++;
      $display("FAIL bub_mats: a=%h b=%h, required a=%h b=%h", a_mat, b_mat, pack_a(a1), pack_b(b1)); end
    tests_run++;
    if ({we_1, we_2} !== 2'b10) begin fails++;
      $display("FAIL bub_we1: we1/we2=%b, required 10", {we_1, we_2}); end
    @(negedge clk);
    tests_run++;
    if ({we_1, we_2, tile_valid} !== 3'b010) begin fails++;
      $display("FAIL bub_we2: we1/we2/tv=%b, required 010", {we_1, we_2, tile_valid}); end
    @(negedge clk);
    tests_run++;
    if (tile_valid !== 1'b1) begin fails++;
      $display("FAIL bub_tv: tv=%b, required 1", tile_valid); end
    tile_ack = 1'b1; @(negedge clk); tile_ack = 1'b0;
  endtask

  task automatic test_reset_mid;
    int strobes;
    for (int i = 0; i < 10; i++) send_byte(a1[i], 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (a_mat !== '0 || b_mat !== '0 || in_ready !== 1'b1 || we_1 !== 1'b0 || we_2 !== 1'b0) begin fails++;
      $display("FAIL rstmid_clear: a=%h b=%h rdy=%b we1=%b we2=%b, required 0 0 1 0 0",
               a_mat, b_mat, in_ready, we_1, we_2); end
    strobes = 0;
    repeat (4) begin @(negedge clk); if (we_1 || we_2 || tile_valid) strobes++; end
    tests_run++;
    if (strobes != 0 || dbg_state !== 3'(LOAD_A)) begin fails++;
      $display("FAIL rstmid_idle: strobe cycles=%0d st=%0d, required 0 %0d", strobes, dbg_state, LOAD_A); end
    send_tile(a3, b3, 1'b0, 0);
    tests_run++;
    if (a_mat !== pack_a(a3) || b_mat !== pack_b(b3) || we_1 !== 1'b1) begin fails++;
      $display("FAIL rstmid_reload: a=%h b=%h we1=%b, required a=%h b=%h we1=1",
               a_mat, b_mat, we_1, pack_a(a3), pack_b(b3)); end
    repeat (2) @(negedge clk);
    tile_ack = 1'b1; @(negedge clk); tile_ack = 1'b0;
  endtask

  task automatic test_spurious_ack;
    for (int i = 0; i < 3; i++) send_byte(8'(11 + i), 1'b0);
    tile_ack = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (dbg_state !== 3'(LOAD_A) || in_ready !== 1'b1 || tile_valid !== 1'b0) begin fails++;
      $display("FAIL spur_a_state: st=%0d rdy=%b tv=%b, required %0d 1 0", dbg_state, in_ready, tile_valid, LOAD_A); end
    send_byte(8'd14, 1'b0);
    tests_run++;
    if (a_mat[31:24] !== 8'd14 || a_mat[39:32] !== 8'h24) begin fails++;
      $display("FAIL spur_a_index: a14=%h a21=%h, required 0e 24", a_mat[31:24], a_mat[39:32]); end
    tile_ack = 1'b0;
    for (int i = 4; i < 16; i++) send_byte(8'(11 + i), 1'b0);
    send_byte(8'h51, 1'b0);
    send_byte(8'h52, 1'b0);
    tile_ack = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (dbg_state !== 3'(LOAD_B) || in_ready !== 1'b1) begin fails++;
      $display("FAIL spur_b_state: st=%0d rdy=%b, required %0d 1", dbg_state, in_ready, LOAD_B); end
    send_byte(8'h53, 1'b0);
    tests_run++;
    if (b_mat[23:16] !== 8'h53 || b_mat[31:24] !== 8'h43) begin fails++;
      $display("FAIL spur_b_index: b13=%h b21=%h, required 53 43", b_mat[23:16], b_mat[31:24]); end
    tile_ack = 1'b0;
    for (int j = 3; j < 9; j++) send_byte(8'(8'h51 + j), 1'b0);
    tests_run++;
    if (we_1 !== 1'b1 || a_mat[127:120] !== 8'd26 || b_mat[71:64] !== 8'h59) begin fails++;
      $display("FAIL spur_done: we1=%b a44=%0d b33=%h, required 1 26 59", we_1, a_mat[127:120], b_mat[71:64]); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) a3[i] = 8'(8'h20 + i);
    for (int j = 0; j < 9; j++)  b3[j] = 8'(8'h40 + j);
    test_reset;
    test_full_load;
    test_backpressure;
    test_kernel_reuse;
    test_bubbles;
    test_reset_mid;
    test_spurious_ack;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule

// File: doc/conv_tile_loader.md
Name: conv_tile_loader

Overview:
Upstream feeder for the parallel convolution datapath. Accepts a byte stream through a valid/ready handshake and assembles one 4x4 input tile plus one 3x3 kernel. It presents both as packed parallel buses, then issues one-cycle write strobes we_1 and we_2 so the datapath latches tile and kernel before its s0 sequencing starts. Optional kernel reuse lets successive tiles load only 16 bytes.

Parameters:
DATA_W, 8, width of each matrix element
A_DIM, 4, input tile dimension (A_DIM x A_DIM elements)
B_DIM, 3, kernel dimension (B_DIM x B_DIM elements)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
in_data  in  DATA_W  stream byte
in_valid  in  1  in_data valid
in_ready  out  1  loader can accept a byte this cycle
keep_kernel  in  1  sampled with the first tile byte; 1 = skip kernel load, keep the previous b_mat
a_mat  out  A_DIM*A_DIM*DATA_W  packed tile; a_rc at bits [DATA_W*(A_DIM*(r-1)+(c-1)) +: DATA_W]
b_mat  out  B_DIM*B_DIM*DATA_W  packed kernel; b_rc packed the same way with B_DIM
we_1  out  1  one-cycle strobe: latch a_mat downstream
we_2  out  1  one-cycle strobe: latch b_mat downstream
tile_valid  out  1  tile and kernel written; held until tile_ack
tile_ack  in  1  downstream finished consuming the tile

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=LOAD_A, index=0, a_mat=0, b_mat=0, we_1=0, we_2=0, tile_valid=0, kept flag=0.
  - Reset mid-load discards the partial tile.
- Accept rule: a byte transfers on a clk edge where in_valid=1 and in_ready=1. in_ready is a registered decode of state: 1 in LOAD_A and LOAD_B, 0 otherwise.
- LOAD_A: each accepted byte is written to element index of a_mat, row-major (index 0 = a11, 15 = a44).
  - keep_kernel is captured into the kept flag on acceptance of index 0.
  - After index 15 is accepted: go to LOAD_B if kept=0, else WR_A. Index returns to 0.
- LOAD_B: accepted bytes fill b_mat row-major (0 = b11, 8 = b33). After index 8: go to WR_A.
- WR_A: we_1=1 for exactly one cycle. Next state is WR_B if kept=0, else HOLD.
- WR_B: we_2=1 for exactly one cycle. Next state: HOLD.
- HOLD: tile_valid=1 and in_ready=0.
  - tile_ack=1 -> LOAD_A next cycle, tile_valid drops to 0 at the same edge.
  - tile_ack outside HOLD is ignored.
- Latency: we_1 is high in the cycle after the final byte is accepted. we_2 follows one cycle later. tile_valid rises one cycle after the last strobe.
- Stalls: in_valid=0 holds index and state indefinitely. Gaps between bytes are legal.
- Outputs: a_mat and b_mat are registers that change only on an accepted byte. They are stable from the we strobe through HOLD.
- With keep_kernel=1 on the first tile after reset, the kernel is all zero; that is legal and needs no special case.
- we_1 and we_2 are never high in the same cycle. No strobe fires without a completed load.
- Index counter width: clog2(A_DIM*A_DIM). The LOAD_B terminal count is B_DIM*B_DIM-1.

Decomposition:
- Shared package conv_pkg holds:
  - DATA_W, A_DIM, B_DIM defaults
  - the state enum {LOAD_A, LOAD_B, WR_A, WR_B, HOLD}
  - derived constants A_ELEMS=16 and B_ELEMS=9
- One natural sub-module: conv_elem_counter, an index counter with load-enable, terminal-count flag and clear. It is instantiated once and shared by LOAD_A and LOAD_B.

Test Plan:
- Full load, keep_kernel=0: stream 1,2,3,4,2,3,4,5,3,4,5,5,3,4,5,5 then 9,8,7,8,7,6,7,6,5 back-to-back.
  - Required: a_mat[7:0]=1, a_mat[127:120]=5, b_mat[7:0]=9, b_mat[71:64]=5.
  - we_1 in the cycle after byte 25, we_2 the next cycle, then tile_valid=1.
- Backpressure: hold in_valid=1 in HOLD for 5 cycles.
  - Required: in_ready=0, no byte consumed. tile_ack -> LOAD_A, and the next byte lands in a11.
- Kernel reuse: second tile of 16 bytes (all 7) with keep_kernel=1.
  - Required: b_mat unchanged (9..5), we_1 pulses, we_2 never asserts, tile_valid one cycle after we_1.
- Bubbles: insert in_valid=0 gaps of 1-3 cycles between every byte.
  - Required: the same final a_mat/b_mat as the first scenario. Strobe timing is relative to the last accepted byte.
- Reset mid-operation: assert rst after byte 10.
  - Required: next cycle a_mat=0, b_mat=0, in_ready=1, no we strobe. A fresh 25-byte load completes normally.
- Spurious ack: tile_ack=1 during LOAD_A/LOAD_B.
  - Required: no state change and no index change.
